// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder split into STAGES carry-ripple slices with a register
//   between slices. Valid/ready on both sides; one beat per cycle when the
//   consumer keeps out_ready high. Reports unsigned carry and signed overflow.
//
//   Optional feature macro: PIPELINED_ADDER_SUB_EN
//     defined   -> adds input `sub`; sub=1 computes in1 + ~in2 + 1 (c_in ignored)
//     undefined -> add only
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when in_valid && in_ready
//   in1, in2   operands (two's complement)
//   c_in       carry into bit 0
//   sub        subtract select (only with PIPELINED_ADDER_SUB_EN)
//   out_valid  result beat valid
//   out_ready  consumer accepts result this cycle
//   sum        in1 + in2 + c_in mod 2^WIDTH
//   c_out      carry out of the MSB
//   ovf        signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             c_in,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int unsigned W    = WIDTH / STAGES;
   localparam int unsigned WP   = W + 1;
   localparam int unsigned LAST = STAGES - 1;
   localparam int unsigned MSB  = WIDTH - 1;

   // Stage s holds the beat before slice s has been added: effective
   // operands (skewed), partial sum of slices below s, and carry into slice s.
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  s_q   [STAGES];
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] v_q;

   logic [WIDTH-1:0]  s_nxt [STAGES];
   logic [STAGES-1:0] cy_nxt;
   logic              ovf_nxt;
   logic              stall;
   logic [WIDTH-1:0]  b_eff;
   logic              c_eff;

   // Effective operand B and carry-in for the incoming beat
   always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
      b_eff = sub ? ~in2 : in2;
      c_eff = sub ? 1'b1 : c_in;
`else
      b_eff = in2;
      c_eff = c_in;
`endif
   end

   // Per-stage slice adders; each merges its slice into the partial sum
   always_comb begin
      logic [W:0] part;
      part   = '0;
      s_nxt  = s_q;
      cy_nxt = '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
         part = {1'b0, a_q[s][s*W +: W]} + {1'b0, b_q[s][s*W +: W]} + WP'(c_q[s]);
         s_nxt[s][s*W +: W] = part[W-1:0];
         cy_nxt[s]          = part[W];
      end
      ovf_nxt = (a_q[LAST][MSB] == b_q[LAST][MSB]) &&
                (s_nxt[LAST][MSB] != a_q[LAST][MSB]);
   end

   // Whole pipeline freezes while the output beat waits for the consumer
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // Pipeline registers and output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            a_q[s] <= '0;
            b_q[s] <= '0;
            s_q[s] <= '0;
         end
         c_q       <= '0;
         v_q       <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         v_q[0] <= in_valid;
         a_q[0] <= in1;
         b_q[0] <= b_eff;
         c_q[0] <= c_eff;
         s_q[0] <= '0;
         for (int unsigned s = 0; s < LAST; s++) begin
            v_q[s+1] <= v_q[s];
            a_q[s+1] <= a_q[s];
            b_q[s+1] <= b_q[s];
            s_q[s+1] <= s_nxt[s];
            c_q[s+1] <= cy_nxt[s];
         end
         out_valid <= v_q[LAST];
         // Result registers only move when a real beat arrives
         if (v_q[LAST]) begin
            sum   <= s_nxt[LAST];
            c_out <= cy_nxt[LAST];
            ovf   <= ovf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//   Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
`ifdef PIPELINED_ADDER_SUB_EN
   logic             sub;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .c_in      (c_in),
`ifdef PIPELINED_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one beat, then wait (bounded) for its result; lat=-1 on timeout
   task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic ci,
                            output logic [31:0] s, output logic co, output logic ov,
                            output int lat);
      in1 = a; in2 = b; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      s = sum; co = c_out; ov = ovf;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in1 = '0; in2 = '0; c_in = 1'b0;
      #12;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0", sum); end
      n_checks++; if ({c_out, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {c_out, ovf}); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      in1 = 32'd3; in2 = 32'd4; c_in = 1'b0; in_valid = 1'b1;
      tick();                                   // edge N accepts beat 1
      in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; c_in = 1'b1;
      tick();                                   // edge N+1 accepts beat 2
      in_valid = 1'b0;
      tick();
      tick();                                   // after edge N+3
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid got %b want 0", out_valid); end
      tick();                                   // after edge N+4
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_beat1_valid got %b want 1", out_valid); end
      n_checks++; if ({sum, c_out, ovf} !== {32'd7, 1'b0, 1'b0})
         begin n_fail++; $display("FAIL b2b_beat1 got sum=%h c=%b o=%b want sum=00000007 c=0 o=0", sum, c_out, ovf); end
      tick();                                   // after edge N+5
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_beat2_valid got %b want 1", out_valid); end
      n_checks++; if ({sum, c_out, ovf} !== {32'hFFFF_FFFF, 1'b1, 1'b0})
         begin n_fail++; $display("FAIL b2b_beat2 got sum=%h c=%b o=%b want sum=ffffffff c=1 o=0", sum, c_out, ovf); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
   endtask

   task automatic test_overflow;
      logic [31:0] va [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] vb [2] = '{32'h0000_0001, 32'h8000_0000};
      logic [31:0] es [2] = '{32'h8000_0000, 32'h0000_0000};
      logic [1:0]  ef [2] = '{2'b01, 2'b11};   // {c_out, ovf}
      logic [31:0] s; logic co, ov; int lat;
      for (int i = 0; i < 2; i++) begin
         send_beat(va[i], vb[i], 1'b0, s, co, ov, lat);
         n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ovf_latency[%0d] got %0d want 4", i, lat); end
         n_checks++; if ({s, co, ov} !== {es[i], ef[i]})
            begin n_fail++; $display("FAIL ovf_vec[%0d] got sum=%h c=%b o=%b want sum=%h c=%b o=%b", i, s, co, ov, es[i], ef[i][1], ef[i][0]); end
      end
   endtask

   task automatic test_negative;
      logic [31:0] va [3] = '{32'hFFFF_FFF6, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] vb [3] = '{32'hFFFF_FFFB, 32'h0000_0001, 32'h0000_0000};
      logic        vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [31:0] es [3] = '{32'hFFFF_FFF1, 32'h0000_0000, 32'h0000_0000};
      logic [1:0]  ef [3] = '{2'b10, 2'b10, 2'b10};
      logic [31:0] s; logic co, ov; int lat;
      for (int i = 0; i < 3; i++) begin
         send_beat(va[i], vb[i], vc[i], s, co, ov, lat);
         n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL neg_latency[%0d] got %0d want 4", i, lat); end
         n_checks++; if ({s, co, ov} !== {es[i], ef[i]})
            begin n_fail++; $display("FAIL neg_vec[%0d] got sum=%h c=%b o=%b want sum=%h c=%b o=%b", i, s, co, ov, es[i], ef[i][1], ef[i][0]); end
      end
   endtask

   task automatic test_backpressure;
      int          idx  = 0;
      int          ridx = 0;
      int          hold = 0;
      logic        seen = 1'b0;
      logic [31:0] held = '0;
      logic        acc, ret;
      out_ready = 1'b1;
      c_in = 1'b0;
      tick();
      for (int cyc = 0; cyc < 200 && ridx < 10; cyc++) begin
         in_valid = (idx < 10);
         in1 = 32'(idx);
         in2 = 32'(idx + 1);
         if (out_valid && !seen) begin
            seen = 1'b1;
            hold = 6;
            held = sum;
            n_checks++; if (held !== 32'd1) begin n_fail++; $display("FAIL bp_first got %h want 00000001", held); end
         end
         out_ready = (hold == 0);
         #1;
         if (hold > 0) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            n_checks++; if ({out_valid, sum} !== {1'b1, held})
               begin n_fail++; $display("FAIL bp_hold got v=%b sum=%h want v=1 sum=%h", out_valid, sum, held); end
            hold--;
         end
         acc = in_valid && in_ready;
         ret = out_valid && out_ready;
         if (ret) begin
            n_checks++; if (sum !== 32'(2 * ridx + 1))
               begin n_fail++; $display("FAIL bp_sum[%0d] got %h want %h", ridx, sum, 32'(2 * ridx + 1)); end
            ridx++;
         end
         tick();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++; if (ridx !== 10 || idx !== 10)
         begin n_fail++; $display("FAIL bp_count got in=%0d out=%0d want 10/10", idx, ridx); end
   endtask

   task automatic test_reset_midstream;
      logic [31:0] s; logic co, ov; int lat;
      out_ready = 1'b1; c_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in1 = 32'(i + 5); in2 = 32'd1; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
      n_checks++; if (sum !== 32'h0) begin n_fail++; $display("FAIL mid_rst_sum got %h want 0", sum); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stale[%0d] got %b want 0", i, out_valid); end
      end
      send_beat(32'd100, 32'd23, 1'b0, s, co, ov, lat);
      n_checks++; if (lat !== 4 || s !== 32'd123)
         begin n_fail++; $display("FAIL mid_rst_recover got lat=%0d sum=%h want lat=4 sum=0000007b", lat, s); end
   endtask

`ifdef PIPELINED_ADDER_SUB_EN
   task automatic test_sub;
      logic [31:0] va [3] = '{32'd10, 32'd5, 32'h8000_0000};
      logic [31:0] vb [3] = '{32'd5, 32'd10, 32'd1};
      logic [31:0] es [3] = '{32'd5, 32'hFFFF_FFFB, 32'h7FFF_FFFF};
      logic [1:0]  ef [3] = '{2'b10, 2'b00, 2'b11};
      logic [31:0] s; logic co, ov; int lat;
      sub = 1'b1;
      for (int i = 0; i < 3; i++) begin
         // c_in driven high to show it is ignored in subtract mode
         send_beat(va[i], vb[i], 1'b1, s, co, ov, lat);
         n_checks++; if (lat !== 4 || {s, co, ov} !== {es[i], ef[i]})
            begin n_fail++; $display("FAIL sub_vec[%0d] got lat=%0d sum=%h c=%b o=%b want lat=4 sum=%h c=%b o=%b", i, lat, s, co, ov, es[i], ef[i][1], ef[i][0]); end
      end
      sub = 1'b0;
   endtask
`endif

   initial begin
`ifdef PIPELINED_ADDER_SUB_EN
      sub = 1'b0;
`endif
      test_reset();
      test_back_to_back();
      test_overflow();
      test_negative();
      test_backpressure();
      test_reset_midstream();
`ifdef PIPELINED_ADDER_SUB_EN
      test_sub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the 32-bit ripple-carry adder. It splits a WIDTH-bit add into STAGES equal carry-ripple slices, with a register between slices. This gives a short critical path and a throughput of one operation per cycle. Valid/ready handshakes on both sides allow it to sit between streaming producers and consumers in the datapath. It also reports signed overflow.

## Interface
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices; each slice adds WIDTH/STAGES bits; 1 ≤ STAGES ≤ WIDTH.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in1  input  WIDTH  operand A, two's complement.
- in2  input  WIDTH  operand B, two's complement.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  in1 + in2 + c_in, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB (unsigned overflow).
- ovf  output  1  signed overflow: both operand signs equal, and the sum sign differs.

## Operation
- Slice s (0..STAGES-1) adds operand bits [s*W+W-1 : s*W], where W = WIDTH/STAGES, plus the registered carry from slice s-1. Slice 0 uses c_in.
- Operand slices not yet consumed travel with the beat through skew registers. Completed sum slices are held until the final stage.
- Each stage has a valid bit. A beat is accepted when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready.
  - While stall is high, every pipeline register holds.
  - in_ready = !stall, combinational.
  - No bubble collapsing is required.
- When not stalled, every stage advances. A stage with no valid beat shifts in a bubble (valid=0).
- ovf is computed in the last stage as (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]). A and B here are the effective operands, after inversion in subtract mode.
- Outputs are registered. sum, c_out and ovf change only when a new beat reaches the output stage.

## Timing
- Reset (rst_n low, asynchronous):
  - all stage valids = 0, so out_valid = 0 and in_ready = 1.
  - sum = 0, c_out = 0, ovf = 0, and all data registers = 0.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+STAGES.
- Throughput: one beat per cycle whenever out_ready is held high.
- Output hold: out_valid=1 with out_ready=0 holds sum/c_out/ovf stable until the handshake completes.
- Simultaneous events: out_ready=1 and in_valid=1 in the same cycle while full means the output retires and a new beat enters on the same edge, with no lost cycle.
- Mid-operation reset: all in-flight beats are discarded. No stale out_valid appears after rst_n deasserts.
- Wrap-around: results are modulo 2^WIDTH, and the carry beyond the MSB appears only on c_out.

## Configuration
- PIPELINED_ADDER_SUB_EN defined:
  - adds port `sub` (input, 1 bit), sampled with the beat.
  - when sub=1, the block computes in1 + ~in2 + 1. c_in is ignored and c_out=1 means no borrow.
  - when sub=0, it computes in1 + in2 + c_in.
- Macro undefined: no `sub` port and no inversion logic; add only.

## Test plan
- WIDTH=32, STAGES=4: beats (3,4,c_in=0) then (0xFFFFFFFF,0xFFFFFFFF,c_in=1) back-to-back with out_ready=1 -> out_valid on the 4th and 5th cycles after acceptance.
  - beat 1: sum=7, c_out=0, ovf=0.
  - beat 2: sum=0xFFFFFFFF, c_out=1, ovf=0.
- Signed overflow: 0x7FFFFFFF + 1 -> sum=0x80000000, ovf=1, c_out=0; 0x80000000 + 0x80000000 -> sum=0, ovf=1, c_out=1.
- Negative operands: -10 + -5 -> sum=0xFFFFFFF1, c_out=1, ovf=0; -1 + 1 -> sum=0, c_out=1, ovf=0.
- Backpressure: stream 10 beats (i, i+1) and hold out_ready=0 for 6 cycles once out_valid rises.
  - in_ready=0 throughout the stall.
  - first result (0+1=1) held stable.
  - after release, all 10 sums 2i+1 appear in order with no loss or duplicates.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0, sum=0 immediately; no outputs for 4 cycles after release until new beats enter.
- With PIPELINED_ADDER_SUB_EN: sub=1, 10 - 5 -> sum=5, c_out=1; 5 - 10 -> sum=0xFFFFFFFB, c_out=0; 0x80000000 - 1 -> ovf=1.
